// File: rtl/hub75_pkg.sv
// hub75_pkg: shared constants and types for the HUB75 receiver.
//   NUM_COLS/NUM_ROWS/BIT_DEPTH : default panel geometry
//   COL_W/ROW_W/PL_W            : derived address/plane widths
//   state_t                     : drain FSM states
//   pix_t                       : one pixel word {rgb0, rgb1}
package hub75_pkg;
  localparam int NUM_COLS  = 64;
  localparam int NUM_ROWS  = 64;
  localparam int BIT_DEPTH = 4;
  localparam int COL_W     = $clog2(NUM_COLS);
  localparam int ROW_W     = $clog2(NUM_ROWS / 2);
  localparam int PL_W      = $clog2(BIT_DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  typedef logic [5:0] pix_t;
endpackage

// File: rtl/hub75_rx_if.sv
// hub75_rx_if: frame-buffer write channel (valid/ready).
//   wr_valid/wr_addr/wr_plane/wr_data : master -> slave
//   wr_ready                          : slave -> master
interface hub75_rx_if #(
  parameter int AW = hub75_pkg::ROW_W + hub75_pkg::COL_W,
  parameter int PW = hub75_pkg::PL_W
);
  import hub75_pkg::*;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_plane;
  pix_t          wr_data;

  modport master (output wr_valid, wr_addr, wr_plane, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_plane, wr_data, output wr_ready);
endinterface

// File: rtl/hub75_sync_edge.sv
// hub75_sync_edge: 2-flop synchroniser plus one history flop for edge
// detection on a W-bit asynchronous bus.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronised value (2 flops)
//   rise/fall: per-bit edge strobes, aligned with q
module hub75_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] s1, s2, h;
  // Edges are masked until the history flop holds a real pin sample, so the
  // reset value of the chain can never look like an edge.
  logic [2:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      h        <= '0;
      vld_pipe <= '0;
    end else begin
      s1       <= d;
      s2       <= s1;
      h        <= s2;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end

  assign q    = s2;
  assign rise = {W{vld_pipe[2]}} &  s2 & ~h;
  assign fall = {W{vld_pipe[2]}} & ~s2 &  h;
endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel-side receiver. Oversamples LP_CLK/LATCH/ROW/RGB on
// clk, deserialises one row per latch and drains it as per-pixel writes.
//   clk, rst            : system clock, synchronous active-high reset
//   hub_clk, hub_latch  : panel shift clock / latch (async)
//   hub_row, hub_rgb0/1 : row address and pixel data (async)
//   wr                  : write channel master {row,col}, plane, {rgb0,rgb1}
//   busy                : drain in progress
//   frame_done          : pulse after the last write of row NUM_ROWS/2-1,
//                         plane BIT_DEPTH-1
//   err_short/overrun   : sticky line-length / latch-while-busy errors
//   clr_err             : clears both sticky errors (a same-cycle set wins)
module hub75_rx #(
  parameter int NUM_COLS         = hub75_pkg::NUM_COLS,
  parameter int NUM_ROWS         = hub75_pkg::NUM_ROWS,
  parameter int BIT_DEPTH        = hub75_pkg::BIT_DEPTH,
  parameter bit SAMPLE_FALL      = 1'b1,
  parameter bit LATCH_ACTIVE_LOW = 1'b1,
  localparam int COL_W = $clog2(NUM_COLS),
  localparam int ROW_W = $clog2(NUM_ROWS / 2),
  localparam int PL_W  = $clog2(BIT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hub_clk,
  input  logic             hub_latch,
  input  logic [ROW_W-1:0] hub_row,
  input  logic [2:0]       hub_rgb0,
  input  logic [2:0]       hub_rgb1,
  hub75_rx_if.master       wr,
  output logic             busy,
  output logic             frame_done,
  output logic             err_short,
  output logic             err_overrun,
  input  logic             clr_err
);
  import hub75_pkg::*;

  localparam int CNT_W = $clog2(NUM_COLS + 1);

  // ---- input synchronisation (all paths share the same latency) ----
  logic [1:0]       ctl_q_unused, ctl_rise, ctl_fall;
  logic [ROW_W+5:0] dat_q, dat_rise_unused, dat_fall_unused;

  hub75_sync_edge #(.W(2)) u_sync_ctl (
    .clk, .rst, .d({hub_clk, hub_latch}),
    .q(ctl_q_unused), .rise(ctl_rise), .fall(ctl_fall)
  );

  hub75_sync_edge #(.W(ROW_W + 6)) u_sync_dat (
    .clk, .rst, .d({hub_row, hub_rgb0, hub_rgb1}),
    .q(dat_q), .rise(dat_rise_unused), .fall(dat_fall_unused)
  );

  logic             shift_edge, latch_edge, accept;
  logic [ROW_W-1:0] row_s;
  pix_t             pix_s;

  assign shift_edge = SAMPLE_FALL      ? ctl_fall[1] : ctl_rise[1];
  assign latch_edge = LATCH_ACTIVE_LOW ? ctl_fall[0] : ctl_rise[0];
  assign row_s      = dat_q[ROW_W+5:6];
  assign pix_s      = dat_q[5:0];
  assign accept     = latch_edge && !busy;

  // ---- shift buffer ----
  pix_t [NUM_COLS-1:0] sbuf, sbuf_nxt, hold;
  logic [CNT_W-1:0]    col_cnt, cnt_nxt;
  logic                ovf_q, ovf_nxt, line_short;

  // The same-cycle pixel is folded in here so a coincident latch copies it.
  always_comb begin
    sbuf_nxt = sbuf;
    cnt_nxt  = col_cnt;
    ovf_nxt  = ovf_q;
    if (shift_edge) begin
      if (col_cnt < CNT_W'(NUM_COLS)) begin
        sbuf_nxt[col_cnt[COL_W-1:0]] = pix_s;
        cnt_nxt = col_cnt + CNT_W'(1);
      end else begin
        ovf_nxt = 1'b1;  // saturated count alone cannot flag a long line
      end
    end
  end

  assign line_short = (cnt_nxt != CNT_W'(NUM_COLS)) || ovf_nxt;

  // ---- line commit, plane tracking, sticky errors ----
  logic [ROW_W-1:0] row_q;
  logic [PL_W-1:0]  plane_q;
  logic             first_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sbuf        <= '0;
      hold        <= '0;
      col_cnt     <= '0;
      ovf_q       <= 1'b0;
      row_q       <= '0;
      plane_q     <= '0;
      first_q     <= 1'b1;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      sbuf    <= sbuf_nxt;
      col_cnt <= latch_edge ? '0 : cnt_nxt;
      ovf_q   <= latch_edge ? 1'b0 : ovf_nxt;
      if (accept) begin
        hold    <= sbuf_nxt;
        row_q   <= row_s;
        first_q <= 1'b0;
        if (first_q || row_s != row_q)          plane_q <= '0;
        else if (plane_q == PL_W'(BIT_DEPTH-1)) plane_q <= '0;
        else                                    plane_q <= plane_q + PL_W'(1);
      end
      if (accept && line_short)    err_short <= 1'b1;
      else if (clr_err)            err_short <= 1'b0;
      if (latch_edge && busy)      err_overrun <= 1'b1;
      else if (clr_err)            err_overrun <= 1'b0;
    end
  end

  // ---- drain FSM ----
  state_t           state, state_nxt;
  logic [COL_W-1:0] dcol;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                              dcol <= '0;
    else if (accept)                      dcol <= '0;
    else if (state == DRAIN && wr.wr_ready) dcol <= dcol + COL_W'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (latch_edge) state_nxt = DRAIN;
      DRAIN:   if (wr.wr_ready && dcol == COL_W'(NUM_COLS-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr.wr_valid = 1'b0;
    wr.wr_addr  = '0;
    wr.wr_plane = '0;
    wr.wr_data  = '0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    case (state)
      DRAIN: begin
        busy        = 1'b1;
        wr.wr_valid = 1'b1;
        wr.wr_addr  = {row_q, dcol};
        wr.wr_plane = plane_q;
        wr.wr_data  = hold[dcol];
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = (row_q == ROW_W'(NUM_ROWS/2-1)) &&
                     (plane_q == PL_W'(BIT_DEPTH-1));
      end
      default: ;
    endcase
  end
endmodule
